// File: rtl/seq_lut_if.sv
// Bundles the operand/table/result signals of seq_lut_detector.
// The master drives the operands and the table. The slave is the detector.
interface seq_lut_if #(
    parameter int N    = 4,
    parameter int CNTW = 8
);
    logic                mode;
    logic                in_valid;
    logic [N-1:0]        x;
    logic                din;
    logic                tt_load;
    logic [(1<<N)-1:0]   tt_data;
    logic                cnt_clr;
    logic                y;
    logic                y_valid;
    logic [N-1:0]        window;
    logic [CNTW-1:0]     match_cnt;

    modport master (
        output mode, in_valid, x, din, tt_load, tt_data, cnt_clr,
        input  y, y_valid, window, match_cnt
    );

    modport slave (
        input  mode, in_valid, x, din, tt_load, tt_data, cnt_clr,
        output y, y_valid, window, match_cnt
    );
endinterface

// File: rtl/seq_lut_detector.sv
// Loadable truth-table evaluator. It takes either a parallel operand or a sliding
// window of serial bits, and it counts how many evaluations returned 1, saturating at the top.
module seq_lut_detector #(
    parameter int                N       = 4,
    parameter int                CNTW    = 8,
    parameter logic [(1<<N)-1:0] TT_INIT = 16'h0EC8
) (
    input  logic     clk,
    input  logic     rst,
    seq_lut_if.slave bus
);
    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);

    typedef enum logic {FILL, RUN} state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic [N-1:0]        window_q, window_d;
    logic                y_q, y_d;
    logic                y_valid_q, y_valid_d;
    logic [(1<<N)-1:0]   tt_q, tt_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic                mode_q;

    logic                mode_chg;
    state_t              state_base;
    logic [FW-1:0]       fill_base;
    logic [N-1:0]        window_base;
    logic [N-1:0]        shifted;

    // NOTE: every combinational output receives a default before any branch, so that no latch is inferred.
    always_comb begin
        // A mode switch restarts serial fill. Any beat accepted in this cycle sees the cleared state.
        mode_chg    = (bus.mode != mode_q);
        state_base  = mode_chg ? FILL : state_q;
        fill_base   = mode_chg ? '0 : fill_q;
        window_base = mode_chg ? '0 : window_q;
        shifted     = {window_base[N-2:0], bus.din};

        state_d   = state_base;
        fill_d    = fill_base;
        window_d  = window_base;
        y_d       = y_q;
        y_valid_d = 1'b0;

        if (bus.in_valid) begin
            if (!bus.mode) begin
                window_d  = bus.x;
                y_d       = tt_q[bus.x];
                y_valid_d = 1'b1;
            end else begin
                window_d = shifted;
                case (state_base)
                    FILL: begin
                        if (fill_base >= FILL_LAST) begin
                            state_d   = RUN;
                            fill_d    = FILL_FULL;
                            y_d       = tt_q[shifted];
                            y_valid_d = 1'b1;
                        end else begin
                            fill_d = fill_base + 1'b1;
                        end
                    end
                    RUN: begin
                        y_d       = tt_q[shifted];
                        y_valid_d = 1'b1;
                    end
                    default: state_d = FILL;
                endcase
            end
        end

        // An evaluation in this cycle uses the old table. The loaded table takes effect from the next cycle.
        tt_d = bus.tt_load ? bus.tt_data : tt_q;

        if (bus.cnt_clr)
            cnt_d = '0;
        else if (y_valid_d && y_d && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
        else
            cnt_d = cnt_q;
    end

    // NOTE: state registers use non-blocking assignments, so that every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FILL;
            fill_q    <= '0;
            window_q  <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            tt_q      <= TT_INIT;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            window_q  <= window_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            tt_q      <= tt_d;
            cnt_q     <= cnt_d;
            mode_q    <= bus.mode;
        end
    end

    assign bus.y         = y_q;
    assign bus.y_valid   = y_valid_q;
    assign bus.window    = window_q;
    assign bus.match_cnt = cnt_q;
endmodule
